// File: rtl/key_event_if.sv
// key_event_if: key pins, debounced key status and the valid/ready event stream of key_event_scan.
interface key_event_if #(
    parameter int NUM_KEYS = 4,
    parameter int IDX_W    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
);
    logic [NUM_KEYS-1:0] key_data;
    logic [NUM_KEYS-1:0] key_state;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic                evt_valid;
    logic                evt_ready;
    logic [IDX_W-1:0]    evt_code;
    logic [1:0]          evt_type;
    logic                evt_overflow;
    modport master (
        input  key_data, evt_ready,
        output key_state, key_press, key_release, evt_valid, evt_code, evt_type, evt_overflow
    );
    modport slave (
        output key_data, evt_ready,
        input  key_state, key_press, key_release, evt_valid, evt_code, evt_type, evt_overflow
    );
endinterface

// File: rtl/key_event_scan.sv
// key_event_scan: per-key debounce, hold timing and a prioritised press/release/long event stream.
// Defining KEY_REPEAT_EN adds periodic REPEAT events while a key stays held after LONG.
module key_event_scan #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    key_event_if.master key_if
);
    localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int CW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW    = $clog2(LONG_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_MAX   = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] H_LONG  = HW'(LONG_CYCLES - 2);
    // Scan order inside one key: PRESS, LONG, REPEAT, RELEASE
    localparam logic [3:0][1:0] PRIO  = {2'd1, 2'd3, 2'd2, 2'd0};
`ifdef KEY_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYCLES - 1);
`endif

    logic [NUM_KEYS-1:0]      w_norm, r_sync1, r_sync2, r_state, r_press, r_release;
    logic [NUM_KEYS-1:0]      w_toggle, w_long, w_rep;
    logic [NUM_KEYS-1:0][3:0] r_pend, w_evt, w_load, w_pend_next;
    logic                     w_take, w_found, w_ovf, r_ovf, r_valid;
    logic [IDX_W-1:0]         w_sel_code, r_code;
    logic [1:0]               w_sel_type, r_type;

    assign w_norm = (ACTIVE_LOW != 0) ? ~key_if.key_data : key_if.key_data;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        logic [CW-1:0] r_cnt;
        logic [HW-1:0] r_hold;
        assign w_toggle[k] = (r_sync2[k] != r_state[k]) && (r_cnt == DB_LAST);
        assign w_long[k]   = r_state[k] && !w_toggle[k] && (r_hold == H_LONG);
        assign w_evt[k]    = {w_rep[k], w_long[k], w_toggle[k] & r_state[k], w_toggle[k] & ~r_state[k]};
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt  <= '0;
                r_hold <= '0;
            end else begin
                r_cnt  <= (r_sync2[k] == r_state[k] || w_toggle[k]) ? '0 : r_cnt + 1'b1;
                r_hold <= (w_toggle[k] && !r_state[k]) ? '0 :
                          (r_state[k] && r_hold != H_MAX) ? r_hold + 1'b1 : r_hold;
            end
        end
`ifdef KEY_REPEAT_EN
        logic          r_rep_on;
        logic [RW-1:0] r_rep;
        assign w_rep[k] = r_rep_on && r_state[k] && !w_toggle[k] && (r_rep == R_LAST);
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rep_on <= 1'b0;
                r_rep    <= '0;
            end else if (w_long[k]) begin
                r_rep_on <= 1'b1;
                r_rep    <= '0;
            end else if (!r_state[k] || w_toggle[k]) begin
                r_rep_on <= 1'b0;
                r_rep    <= '0;
            end else if (r_rep_on) begin
                r_rep    <= w_rep[k] ? '0 : r_rep + 1'b1;
            end
        end
`else
        assign w_rep[k] = 1'b0;
`endif
    end

    assign w_take = !r_valid || key_if.evt_ready;

    always_comb begin
        w_found    = 1'b0;
        w_sel_code = '0;
        w_sel_type = '0;
        w_load     = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            for (int p = 0; p < 4; p++) begin
                if (!w_found && r_pend[k][PRIO[p]]) begin
                    w_found              = 1'b1;
                    w_sel_code           = IDX_W'(k);
                    w_sel_type           = PRIO[p];
                    w_load[k][PRIO[p]]   = w_take;
                end
            end
        end
    end

    // An event landing on the cycle its previous instance is loaded is kept, not lost
    assign w_pend_next = (r_pend & ~w_load) | w_evt;
    assign w_ovf       = |(w_evt & r_pend & ~w_load);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_state   <= '0;
            r_press   <= '0;
            r_release <= '0;
            r_pend    <= '0;
            r_ovf     <= 1'b0;
            r_valid   <= 1'b0;
            r_code    <= '0;
            r_type    <= '0;
        end else begin
            r_sync1   <= w_norm;
            r_sync2   <= r_sync1;
            r_state   <= r_state ^ w_toggle;
            r_press   <= w_toggle & ~r_state;
            r_release <= w_toggle & r_state;
            r_pend    <= w_pend_next;
            r_ovf     <= w_ovf;
            if (w_take) begin
                r_valid <= w_found;
                r_code  <= w_sel_code;
                r_type  <= w_sel_type;
            end
        end
    end

    assign key_if.key_state    = r_state;
    assign key_if.key_press    = r_press;
    assign key_if.key_release  = r_release;
    assign key_if.evt_valid    = r_valid;
    assign key_if.evt_code     = r_code;
    assign key_if.evt_type     = r_type;
    assign key_if.evt_overflow = r_ovf;
endmodule
